inert_serf_model: RTL and testbench
===================================

// Module: inert_serf_model
// PURPOSE
//  SPI serf model of the 6-axis inertial sensor, i.e. the responder side of the gyro interface.
//  Decodes 16-bit SPI frames: cmd[15]=R/W (1=read), cmd[14:8]=addr, cmd[7:0]=write data.
//  Holds the config registers and generates INT at a fixed rate once configured.
//  Returns a latched 16-bit yaw-rate sample over two byte reads.
//  Used in the full-chip bench and on FPGA bring-up in place of the real sensor.
// PARAMETERS
//  INT_PERIOD  1024   clk cycles between new-sample events (fast-sim value)
//  WHO_AM_I    8'h6A  value returned for reads of addr 0x0F
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   reset, asynchronous, active-low
//  SS_n     in   1   SPI select from monarch, active-low (asynchronous to clk)
//  SCLK     in   1   SPI clock from monarch; idles high
//  MOSI     in   1   SPI data in, MSB first
//  MISO     out  1   SPI data out, MSB first
//  INT      out  1   high while an unread yaw sample is held
//  yaw_in   in   16  yaw-rate value captured at each sample event
//  cfg_rdy  out  1   high when INT generation is enabled (see below)
//  ovr      out  1   1-clk pulse when a sample event is dropped because INT is still high
// BEHAVIOUR
//  Input sync
//   - SS_n, SCLK, MOSI each pass through a 2-flop synchronizer.
//   - A 3rd SCLK/SS_n flop provides edge detection.
//   - All actions below are on synchronized edges.
//  SM states
//   - WAIT_HI (reset state): go to IDLE when SS_n is high. A frame in progress at reset is ignored.
//   - IDLE: on SS_n fall, clear shft_reg and bit_cnt, then go to SHIFT.
//   - SHIFT: on each SCLK rise, shft_reg <= {shft_reg[14:0],MOSI} and bit_cnt++ (saturates at 16).
//     On the clk where bit_cnt goes 7->8 and the shifted-in cmd bit 15 is 1,
//     shft_reg[15:8] is loaded with the read data for addr.
//     On SS_n rise, go to IDLE.
//  MISO
//   - MISO = shft_reg[15]; reset value 0.
//   - First byte reads 0x00; second byte is the register data.
//   - MISO changes 3-4 clks after an SCLK rise and is stable through the next rise.
//  Frame completion (SS_n rise)
//   - Only a frame with bit_cnt==16 is complete.
//   - Complete write: store cmd[7:0] if addr is 0x0D, 0x11 or 0x14. All other addrs are ignored.
//   - Complete read of 0x27: clear INT on the next clk.
//   - Frames with bit_cnt!=16 are aborted: no write and no INT clear.
//  Read map
//   - 0x0D, 0x11, 0x14: stored value.
//   - 0x0F: WHO_AM_I.
//   - 0x26: yaw_hold[7:0].
//   - 0x27: yaw_hold[15:8].
//   - Any other addr: 0x00.
//  Reset values
//   - Config regs = 0x00; yaw_hold = 0.
//   - INT=0, ovr=0, MISO=0, cfg_rdy=0.
//  Sample events
//   - cfg_rdy = (reg0D==8'h02) && (reg11[7:4]!=0).
//   - Timer counts 0..INT_PERIOD-1 and wraps, only while cfg_rdy=1. It is held at 0 otherwise.
//   - At wrap with INT=0: yaw_hold<=yaw_in and INT<=1 (same clk).
//   - At wrap with INT=1: yaw_hold is kept (coherent L/H pair) and ovr pulses.
//   - Wrap and an INT-clearing frame end on the same clk: the clear is applied first, then the new sample sets INT.
//     Net: INT stays 1 and yaw_hold is updated.
//   - Reading 0x26 alone does not clear INT.
//   - cfg_rdy going low leaves a pending INT set until 0x27 is read.
// TESTING
//  1. Config: frames 0x0D02, 0x1160, 0x1440 -> cfg_rdy=1 after 2nd frame; INT rises INT_PERIOD clks later.
//  2. yaw_in=16'h1234 at event: frame 0xA600 -> rd byte 0x34; frame 0xA700 -> 0x12; INT low <=3 clks after SS_n rise.
//  3. Frame 0x8F00 -> 0x6A. Frame 0x9900 -> 0x00. Frame 0x0F55 -> no state change.
//  4. Abort: SS_n rises after 10 SCLKs of 0x0D00 -> reg0D stays 0x02; 0xA7 read aborted at 12 bits -> INT stays 1.
//  5. Overrun: no reads for 2 periods -> one ovr pulse; the next reads return the first sample.
//     Wrap coincident with 0xA7 frame end -> INT stays 1 with the new sample.
//  6. Reset asserted mid-frame with SS_n low -> MISO=0, INT=0; remaining SCLKs ignored; next full frame decodes.

Source files
------------

// File: rtl/inert_serf_if.sv
// SPI link between the monarch and the inertial-sensor serf model.
interface inert_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_serf_model.sv
// SPI responder model of the 6-axis inertial sensor: config regs, timed yaw
// samples with INT/overrun, and 16-bit command frames decoded on synced edges.
//   state   | meaning
//   WAIT_HI | out of reset; wait for SS_n high so a partial frame is skipped
//   IDLE    | between frames; SS_n fall starts a new frame
//   SHIFT   | frame active; shift on SCLK rise, finish on SS_n rise
module inert_serf_model #(
    parameter int         INT_PERIOD = 1024,
    parameter logic [7:0] WHO_AM_I   = 8'h6A
) (
    input  logic         clk,
    input  logic         rst_n,
    inert_serf_if.slave  spi,
    output logic         INT,
    input  logic [15:0]  yaw_in,
    output logic         cfg_rdy,
    output logic         ovr
);

    localparam int TW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;

    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    ss_sync, sclk_sync;
    logic [1:0]    mosi_sync;
    logic          ss_hi, ss_fall, ss_rise, sclk_rise, mosi_s;
    logic          frame_clr, frame_end, shift_en;
    logic [4:0]    bit_cnt;
    logic [15:0]   shft_reg;
    logic [6:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          load_rd, frame_ok, wr_en, int_clr, wrap, int_busy;
    logic [7:0]    reg_0d, reg_11, reg_14;
    logic [15:0]   yaw_hold;
    logic [TW-1:0] tmr;

    // SS_n sync flops reset low so a select held low through reset never looks like a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b000;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[0], spi.MOSI};
        end
    end

    assign ss_hi     = ss_sync[1];
    assign ss_fall   = ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign mosi_s    = mosi_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HI;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_clr = 1'b0;
        frame_end = 1'b0;
        shift_en  = 1'b0;
        case (state)
            WAIT_HI: if (ss_hi) state_nxt = IDLE;
            IDLE: begin
                if (ss_fall) begin
                    frame_clr = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_nxt = WAIT_HI;
        endcase
    end

    // On the 8th bit the command byte is complete: {shft_reg[6:0], mosi_s}
    assign rd_addr = {shft_reg[5:0], mosi_s};
    assign load_rd = shift_en && (bit_cnt == 5'd7) && shft_reg[6];

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            7'h0D:   rd_data = reg_0d;
            7'h11:   rd_data = reg_11;
            7'h14:   rd_data = reg_14;
            7'h0F:   rd_data = WHO_AM_I;
            7'h26:   rd_data = yaw_hold[7:0];
            7'h27:   rd_data = yaw_hold[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_reg <= '0;
            bit_cnt  <= '0;
        end else if (frame_clr) begin
            shft_reg <= '0;
            bit_cnt  <= '0;
        end else if (shift_en) begin
            shft_reg <= load_rd ? {rd_data, shft_reg[6:0], mosi_s}
                                : {shft_reg[14:0], mosi_s};
            if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign spi.MISO = shft_reg[15];

    // At frame end shft_reg holds {rw, addr, data} for both reads and writes
    assign frame_ok = frame_end && (bit_cnt == 5'd16);
    assign wr_en    = frame_ok && !shft_reg[15];
    assign int_clr  = frame_ok && shft_reg[15] && (shft_reg[14:8] == 7'h27);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_0d <= 8'h00;
            reg_11 <= 8'h00;
            reg_14 <= 8'h00;
        end else if (wr_en) begin
            case (shft_reg[14:8])
                7'h0D:   reg_0d <= shft_reg[7:0];
                7'h11:   reg_11 <= shft_reg[7:0];
                7'h14:   reg_14 <= shft_reg[7:0];
                default: ;
            endcase
        end
    end

    assign cfg_rdy = (reg_0d == 8'h02) && (reg_11[7:4] != 4'h0);
    assign wrap    = cfg_rdy && (tmr == TW'(INT_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tmr <= '0;
        else if (!cfg_rdy || wrap) tmr <= '0;
        else                     tmr <= tmr + TW'(1);
    end

    // A clear landing on the wrap clk frees the holder for the new sample
    assign int_busy = INT && !int_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            INT      <= 1'b0;
            ovr      <= 1'b0;
            yaw_hold <= '0;
        end else begin
            ovr <= 1'b0;
            if (wrap) begin
                if (!int_busy) begin
                    yaw_hold <= yaw_in;
                    INT      <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (int_clr) begin
                INT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inert_serf_model.sv
// Self-checking bench for inert_serf_model: SPI monarch tasks, read-data
// scoreboard, and cycle-tracked sample-event, overrun and reset scenarios.
module tb_inert_serf_model;
    localparam int P = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT, cfg_rdy, ovr;
    logic [15:0] yaw_in;

    inert_serf_if spi();

    inert_serf_model #(.INT_PERIOD(P), .WHO_AM_I(8'h6A)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi), .INT(INT),
        .yaw_in(yaw_in), .cfg_rdy(cfg_rdy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          cfg_rise_cyc = 0;
    int          int_rise_cyc = 0;
    int          ovr_hi = 0;
    logic        int_prev = 1'b0;
    logic        cfg_prev = 1'b0;
    logic [15:0] exp_q[$];
    int          n0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_rdy === 1'b1 && cfg_prev !== 1'b1) cfg_rise_cyc = cyc;
        if (INT === 1'b1 && int_prev !== 1'b1) int_rise_cyc = cyc;
        if (ovr === 1'b1) ovr_hi++;
        cfg_prev = cfg_rdy;
        int_prev = INT;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic spi_begin();
        spi.SS_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] cmd, input int first, input int last,
                            inout logic [15:0] rx);
        for (int i = first; i <= last; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = cmd[15-i];
            repeat (4) @(negedge clk);
            rx[15-i] = spi.MISO;
            spi.SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic spi_xfer(input logic [15:0] cmd);
        logic [15:0] rx;
        rx = '0;
        spi_begin();
        spi_bits(cmd, 0, 15, rx);
        spi.SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic sb_compare(input string tag, input logic [15:0] rx);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {16'h0, rx}, {16'h0, exp});
        end
    endtask

    // Full read frame; int_after is INT sampled 3 clks after SS_n rises
    task automatic spi_read(input logic [6:0] addr, input logic [7:0] exp_byte,
                            input string tag, output logic int_after);
        logic [15:0] rx;
        rx = '0;
        exp_q.push_back({8'h00, exp_byte});
        spi_begin();
        spi_bits({1'b1, addr, 8'h00}, 0, 15, rx);
        spi.SS_n = 1'b1;
        repeat (3) @(negedge clk);
        int_after = INT;
        repeat (5) @(negedge clk);
        sb_compare(tag, rx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ia;
        logic [15:0] rx;
        rx = '0;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        yaw_in   = 16'h1234;
        repeat (3) @(negedge clk);
        check("rst_miso", spi.MISO, 0);
        check("rst_int", INT, 0);
        check("rst_ovr", ovr, 0);
        check("rst_cfg_rdy", cfg_rdy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // configuration
        spi_xfer(16'h0D02);
        check("cfg_rdy_after_0d", cfg_rdy, 0);
        spi_xfer(16'h1160);
        check("cfg_rdy_after_11", cfg_rdy, 1);
        spi_xfer(16'h1440);
        spi_read(7'h14, 8'h40, "rd_14", ia);
        spi_read(7'h11, 8'h60, "rd_11", ia);
        for (int i = 0; i < 3 * P && INT !== 1'b1; i++) @(negedge clk);
        check("int_rise", INT, 1);
        @(negedge clk);
        n0 = int_rise_cyc;
        check("int_latency", n0 - cfg_rise_cyc, P);

        // yaw readout of first sample, INT clears on 0x27 read only
        yaw_in = 16'hBEEF;
        spi_read(7'h26, 8'h34, "rd_yaw_lo", ia);
        check("int_after_26", ia, 1);
        spi_read(7'h27, 8'h12, "rd_yaw_hi", ia);
        check("int_after_27", ia, 0);

        spi_read(7'h0F, 8'h6A, "rd_who", ia);
        spi_read(7'h19, 8'h00, "rd_unmapped", ia);
        spi_xfer(16'h0F55);
        spi_read(7'h0F, 8'h6A, "rd_who_again", ia);

        // aborted write leaves reg0D intact
        spi_begin();
        spi_bits(16'h0D00, 0, 9, rx);
        spi.SS_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_read(7'h0D, 8'h02, "rd_0d_after_abort", ia);
        check("cfg_rdy_after_abort", cfg_rdy, 1);

        // second sample (0xBEEF); aborted 0x27 read must not clear INT
        wait_until(n0 + P + 10);
        check("int_w1", INT, 1);
        yaw_in = 16'h5555;
        spi_begin();
        spi_bits(16'hA700, 0, 11, rx);
        spi.SS_n = 1'b1;
        repeat (8) @(negedge clk);
        check("int_after_abort_27", INT, 1);

        // overrun: holder keeps 0xBEEF across the next event
        wait_until(n0 + 2 * P + 10);
        check("ovr_pulses", ovr_hi, 1);
        check("int_w2", INT, 1);
        spi_read(7'h26, 8'hEF, "rd_ovr_lo", ia);
        spi_read(7'h27, 8'hBE, "rd_ovr_hi", ia);
        check("int_after_ovr_27", ia, 0);

        // next event takes 0x5555; then clear coincident with the following event
        wait_until(n0 + 3 * P + 10);
        check("int_w3", INT, 1);
        yaw_in = 16'hC3A5;
        wait_until(n0 + 4 * P - 200);
        exp_q.push_back(16'h0055);
        spi_begin();
        spi_bits(16'hA700, 0, 15, rx);
        wait_until(n0 + 4 * P - 3);
        spi.SS_n = 1'b1;
        wait_until(n0 + 4 * P);
        check("int_coincident", INT, 1);
        repeat (5) @(negedge clk);
        check("int_coincident_late", INT, 1);
        sb_compare("rd_coinc_hi", rx);
        check("ovr_after_coinc", ovr_hi, 1);
        spi_read(7'h26, 8'hA5, "rd_new_lo", ia);
        check("int_after_new_26", ia, 1);
        spi_read(7'h27, 8'hC3, "rd_new_hi", ia);
        check("int_after_new_27", ia, 0);

        // reset in the middle of a read frame
        wait_until(n0 + 5 * P + 10);
        check("int_w5", INT, 1);
        spi_begin();
        spi_bits(16'h8F00, 0, 9, rx);
        check("miso_pre_rst", spi.MISO, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_miso", spi.MISO, 0);
        check("midrst_int", INT, 0);
        check("midrst_cfg_rdy", cfg_rdy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spi_bits(16'h8F00, 10, 15, rx);
        check("miso_ignored_sclk", spi.MISO, 0);
        spi.SS_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_read(7'h11, 8'h00, "rd_11_after_rst", ia);
        spi_xfer(16'h0D02);
        spi_read(7'h0D, 8'h02, "rd_0d_after_rst", ia);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
